hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the decode stage.
- Detects load-use hazards between EX and ID and inserts bubbles.
- Squashes wrong-path fetches after a taken branch, jal or jalr redirect, and freezes the pipeline while data memory is busy.
- Drives the PC/IF-ID/ID-EX enables and flushes, plus the `valid` input of the decode stage. Keeps saturating stall and flush performance counters.

Parameters:
- RegAddress, 5, register index width.
- FlushCycles, 1, IF/ID squash cycles per redirect (legal range 1..7).
- CntWidth, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- id_rs1  in  RegAddress  rs1 of the instruction in ID.
- id_rs2  in  RegAddress  rs2 of the instruction in ID.
- id_inst_valid  in  1  ID holds a real (non-bubble) instruction.
- ex_load  in  1  instruction in EX is a load.
- ex_rd  in  RegAddress  destination register of the EX instruction.
- redirect  in  1  taken branch_result, jal (next_sel) or jalr resolved in ID.
- mem_busy  in  1  data memory stall request.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_en  out  1  PC register update enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load bubble into ID/EX.
- dec_valid  out  1  drives decode `valid`.
- stall_cnt  out  CntWidth  cycles lost to load-use stalls or mem_busy.
- flush_cnt  out  CntWidth  number of redirects accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- States: INIT, RUN, FLUSH, WAIT. State register, flush counter (3 bits) and stat counters are flops; all other outputs are combinational from state and inputs.
- Reset (rst=0): state=INIT, flush counter=0, stall_cnt=0, flush_cnt=0. Outputs during reset and INIT: pc_en=0, if_id_en=0, id_ex_en=0, if_id_flush=1, id_ex_flush=1, dec_valid=0.
- INIT: always goes to RUN on the next clk edge.
- Load-use hazard (RUN only): `lu = id_inst_valid & ex_load & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2)`.
- Priority in RUN, highest first:
  1. mem_busy=1: all enables 0, no flushes, dec_valid=id_inst_valid; next state WAIT; stall_cnt+1.
  2. lu=1: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, dec_valid=0; stay RUN; stall_cnt+1. A redirect in the same cycle is ignored; it is re-evaluated next cycle with forwarded operands.
  3. redirect & id_inst_valid: pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, dec_valid=1 (jump proceeds for its link write); flush_cnt+1. If FlushCycles>1: load flush counter with FlushCycles-1 and go FLUSH; else stay RUN.
  4. Otherwise: all enables 1, no flushes, dec_valid=id_inst_valid.
- FLUSH:
  - pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1, dec_valid=0. redirect and lu are ignored.
  - Counter decrements each cycle; at 1→0 go RUN.
  - mem_busy=1 in FLUSH: all enables 0, no flushes, counter holds, state holds, stall_cnt+1.
- WAIT:
  - Same outputs as RUN case 1 while mem_busy=1; stall_cnt+1 each cycle.
  - On mem_busy=0, go RUN and evaluate the RUN rules in that same cycle (combinational).
- Counters: saturate at all-ones and never wrap. cnt_clr has priority over increment (value becomes 0 that cycle).
- ex_rd=0 never causes a stall.
- Reset mid-FLUSH or mid-WAIT returns immediately to INIT values.
- No X on any output after reset.

Test Plan:
- Reset then release → one INIT cycle with all enables 0 and flushes 1, then RUN with pc_en=if_id_en=id_ex_en=1 and counters 0.
- ex_load=1, ex_rd=5, id_rs2=5, id_inst_valid=1 → exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Repeat with ex_rd=0 → no stall.
- redirect=1 at FlushCycles=3 → redirect cycle plus 2 FLUSH cycles with if_id_flush=1 and dec_valid=0, then RUN; flush_cnt=1.
- Same cycle lu=1 and redirect=1 → stall only, flush_cnt unchanged. Next cycle (lu=0) redirect is accepted and flush_cnt=1.
- mem_busy held 4 cycles during FLUSH (counter=1) → enables 0 for 4 cycles, counter holds, stall_cnt+=4, one remaining flush cycle after release.
- stall_cnt preloaded to all-ones via a long stall → stays all-ones. cnt_clr asserted together with a stall → counter becomes 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Decode-stage pipeline sequencer: load-use bubbles, redirect squash,
// data-memory freeze, and saturating stall/flush performance counters.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   INIT  | first cycle out of reset, pipeline held and squashed
//   RUN   | normal issue; load-use, redirect and mem_busy resolved here
//   FLUSH | squashing wrong-path fetches after an accepted redirect
//   WAIT  | frozen on mem_busy; RUN rules apply as soon as it drops
module hazard_ctrl #(
    parameter int RegAddress  = 5,
    parameter int FlushCycles = 1,
    parameter int CntWidth    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RegAddress-1:0] id_rs1,
    input  logic [RegAddress-1:0] id_rs2,
    input  logic                  id_inst_valid,
    input  logic                  ex_load,
    input  logic [RegAddress-1:0] ex_rd,
    input  logic                  redirect,
    input  logic                  mem_busy,
    input  logic                  cnt_clr,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  dec_valid,
    output logic [CntWidth-1:0]   stall_cnt,
    output logic [CntWidth-1:0]   flush_cnt
);

    typedef enum logic [1:0] {INIT, RUN, FLUSH, WAIT} state_t;

    localparam logic [2:0]          FLUSH_LOAD = 3'(FlushCycles - 1);
    localparam logic [CntWidth-1:0] CNT_MAX    = '1;

    state_t      state, state_nxt;
    logic [2:0]  fcnt, fcnt_nxt;
    logic        lu;
    logic        stall_inc;
    logic        flush_inc;

    assign lu = id_inst_valid & ex_load & (ex_rd != '0) &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        dec_valid   = 1'b0;
        state_nxt   = state;
        fcnt_nxt    = fcnt;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (state)
            INIT: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt   = RUN;
            end
            // WAIT with mem_busy low falls straight into the RUN rules
            RUN, WAIT: begin
                if (mem_busy) begin
                    dec_valid = id_inst_valid;
                    stall_inc = 1'b1;
                    state_nxt = WAIT;
                end else if (lu) begin
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    stall_inc   = 1'b1;
                    state_nxt   = RUN;
                end else if (redirect && id_inst_valid) begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_en    = 1'b1;
                    dec_valid   = 1'b1;
                    flush_inc   = 1'b1;
                    if (FlushCycles > 1) begin
                        fcnt_nxt  = FLUSH_LOAD;
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt = RUN;
                    end
                end else begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    dec_valid = id_inst_valid;
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                if (mem_busy) begin
                    stall_inc = 1'b1;
                end else begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    fcnt_nxt    = fcnt - 3'd1;
                    if (fcnt <= 3'd1) begin
                        fcnt_nxt  = 3'd0;
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt   = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= INIT;
            fcnt      <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (cnt_clr) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
            end else begin
                if (stall_inc && stall_cnt != CNT_MAX)
                    stall_cnt <= stall_cnt + 1'b1;
                if (flush_inc && flush_cnt != CNT_MAX)
                    flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FlushCycles=3 and 4-bit counters so
// saturation is reachable in a few cycles.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_inst_valid, ex_load, redirect, mem_busy, cnt_clr;
    logic       pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, dec_valid;
    logic [3:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, dec_valid}
    localparam logic [5:0] O_INIT  = 6'b000_11_0;
    localparam logic [5:0] O_RUNV  = 6'b111_00_1;
    localparam logic [5:0] O_RUNN  = 6'b111_00_0;
    localparam logic [5:0] O_LU    = 6'b001_01_0;
    localparam logic [5:0] O_REDIR = 6'b111_10_1;
    localparam logic [5:0] O_FLUSH = 6'b111_11_0;
    localparam logic [5:0] O_HOLD  = 6'b000_00_0;
    localparam logic [5:0] O_HOLDV = 6'b000_00_1;

    hazard_ctrl #(.RegAddress(5), .FlushCycles(3), .CntWidth(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_inst_valid(id_inst_valid),
        .ex_load(ex_load), .ex_rd(ex_rd), .redirect(redirect),
        .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .dec_valid(dec_valid), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, dec_valid},
            {26'd0, exp});
    endtask

    task automatic cyc(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic ld, input logic [4:0] rd, input logic rdr,
                       input logic mb, input logic clr);
        @(negedge clk);
        id_inst_valid = v;
        id_rs1        = rs1;
        id_rs2        = rs2;
        ex_load       = ld;
        ex_rd         = rd;
        redirect      = rdr;
        mem_busy      = mb;
        cnt_clr       = clr;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_inst_valid = 1'b0; ex_load = 1'b0; redirect = 1'b0;
        mem_busy = 1'b0; cnt_clr = 1'b0;
        #1;
        chk_out("reset_out", O_INIT);
        chk("reset_stall", 32'(stall_cnt), 0);
        chk("reset_flush", 32'(flush_cnt), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk_out("init_out", O_INIT);

        cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        chk_out("run_out", O_RUNV);
        chk("run_stall", 32'(stall_cnt), 0);

        // load-use on rs2
        cyc(1, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0);
        chk_out("lu_rs2_out", O_LU);
        cyc(1, 5'd1, 5'd5, 0, 5'd5, 0, 0, 0);
        chk_out("lu_after_out", O_RUNV);
        chk("lu_stall", 32'(stall_cnt), 1);
        // ex_rd = 0 never stalls
        cyc(1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
        chk_out("rd0_out", O_RUNV);
        // bubble in ID never stalls
        cyc(0, 5'd7, 5'd2, 1, 5'd7, 0, 0, 0);
        chk_out("bubble_out", O_RUNN);
        chk("rd0_stall", 32'(stall_cnt), 1);

        // redirect with FlushCycles=3: redirect + 2 flush cycles
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0);
        chk_out("redir_out", O_REDIR);
        chk("redir_flush_pre", 32'(flush_cnt), 0);
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0);
        chk_out("flush1_out", O_FLUSH);
        chk("flush1_cnt", 32'(flush_cnt), 1);
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        chk_out("flush2_out", O_FLUSH);
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        chk_out("flush_done_out", O_RUNV);
        chk("flush_ignored_cnt", 32'(flush_cnt), 1);

        // lu and redirect together: stall wins
        cyc(1, 5'd3, 5'd2, 1, 5'd3, 1, 0, 0);
        chk_out("lu_redir_out", O_LU);
        cyc(1, 5'd3, 5'd2, 0, 5'd3, 1, 0, 0);
        chk_out("redir_retry_out", O_REDIR);
        chk("lu_redir_flush", 32'(flush_cnt), 1);
        chk("lu_redir_stall", 32'(stall_cnt), 2);
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        chk_out("flushA_out", O_FLUSH);
        chk("redir_retry_cnt", 32'(flush_cnt), 2);

        // mem_busy while flush counter = 1
        for (int i = 0; i < 4; i++) begin
            cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
            chk_out("flush_busy_out", O_HOLD);
        end
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        chk_out("flush_resume_out", O_FLUSH);
        chk("flush_busy_stall", 32'(stall_cnt), 6);
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        chk_out("flush_end_out", O_RUNV);

        // mem_busy in RUN, then WAIT release straight into a load-use stall
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
        chk_out("busy_run_out", O_HOLDV);
        cyc(0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
        chk_out("wait_out", O_HOLD);
        chk("wait_stall", 32'(stall_cnt), 7);
        cyc(1, 5'd4, 5'd2, 1, 5'd4, 0, 0, 0);
        chk_out("wait_release_lu", O_LU);
        chk("wait_release_stall", 32'(stall_cnt), 8);
        cyc(1, 5'd4, 5'd2, 0, 5'd4, 0, 0, 0);
        chk_out("post_wait_out", O_RUNV);
        chk("post_wait_stall", 32'(stall_cnt), 9);

        // reset mid-WAIT
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
        chk_out("wait2_out", O_HOLDV);
        rst = 1'b0;
        #1;
        chk_out("rst_wait_out", O_INIT);
        chk("rst_wait_stall", 32'(stall_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        mem_busy = 1'b0;
        #1;
        chk_out("rst_wait_init", O_INIT);

        // reset mid-FLUSH
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 1, 0, 0);
        chk_out("redir2_out", O_REDIR);
        cyc(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        chk_out("flushB_out", O_FLUSH);
        chk("flushB_cnt", 32'(flush_cnt), 1);
        rst = 1'b0;
        #1;
        chk_out("rst_flush_out", O_INIT);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_out("rst_flush_init", O_INIT);

        // stall counter saturation, then clear beats increment
        for (int i = 0; i < 20; i++) begin
            cyc(0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
            chk_out("sat_busy_out", O_HOLD);
        end
        cyc(0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1);
        chk("sat_stall", 32'(stall_cnt), 15);
        cyc(0, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
        chk("clr_stall", 32'(stall_cnt), 0);
        cyc(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        chk("after_clr_stall", 32'(stall_cnt), 1);
        chk_out("final_out", O_RUNN);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
